mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one req/gnt/rvalid memory port between the pipeline's instruction-fetch master and its LSU data master.
//  Sits between cpu_pipeline (instr_* / data_* buses) and a single-ported memory or bus bridge.
//  Arbitrates new requests and tracks in-flight requests in an owner FIFO.
//  Routes in-order responses back to the master that issued them.
// PARAMETERS
//  MAX_OUTST  2  max in-flight (granted, not yet responded) requests; >=1
//  DATA_PRIO  1  1: data master always wins contention; 0: round-robin between masters
// PORTS
//  CLK            in   1   clock, all state on rising edge
//  RST            in   1   synchronous, active-high reset
//  instr_req_i    in   1   fetch request
//  instr_addr_i   in   32  fetch address
//  instr_gnt_o    out  1   fetch request accepted this cycle
//  instr_rvalid_o out  1   fetch response valid
//  instr_rdata_o  out  32  fetch response data
//  instr_err_o    out  1   fetch response error
//  data_req_i     in   1   LSU request
//  data_we_i      in   1   LSU write enable
//  data_be_i      in   4   LSU byte enables
//  data_addr_i    in   32  LSU address
//  data_wdata_i   in   32  LSU write data
//  data_gnt_o     out  1   LSU request accepted
//  data_rvalid_o  out  1   LSU response valid
//  data_rdata_o   out  32  LSU read data
//  data_err_o     out  1   LSU response error
//  mem_req_o      out  1   memory request
//  mem_we_o       out  1   memory write enable
//  mem_be_o       out  4   memory byte enables
//  mem_addr_o     out  32  memory address
//  mem_wdata_o    out  32  memory write data
//  mem_gnt_i      in   1   memory accepted request
//  mem_rvalid_i   in   1   memory response valid (in order)
//  mem_rdata_i    in   32  memory response data
//  mem_err_i      in   1   memory response error
//  outst_cnt_o    out  $clog2(MAX_OUTST+1)  in-flight count
//  proto_err_o    out  1   sticky: rvalid seen with nothing in flight
// BEHAVIOUR
//  Reset:
//   - owner FIFO empty; outst_cnt_o=0; proto_err_o=0.
//   - lock cleared; last_winner=INSTR.
//   - All *_gnt_o / *_rvalid_o / mem_req_o are 0 while RST is high.
//  Request path (combinational, zero latency):
//   - full = (outst_cnt_o==MAX_OUTST).
//   - When full: mem_req_o=0 and both gnts=0, even if an rvalid pops this cycle.
//   - Select: if lock set, the locked master; else the sole requester;
//     on contention, data if DATA_PRIO=1, otherwise the master != last_winner.
//   - Selected INSTR: mem_we_o=0, mem_be_o=4'hF, mem_addr_o=instr_addr_i, mem_wdata_o=0.
//   - Selected DATA: pass-through of data_* fields.
//   - No selection: mem_addr_o, mem_wdata_o, mem_be_o, mem_we_o driven to 0.
//   - mem_req_o = selected master's req & ~full.
//   - sel_gnt_o = mem_req_o & mem_gnt_i; the other gnt is 0.
//  Lock (request stability):
//   - Set when mem_req_o=1 & mem_gnt_i=0; holds the current selection.
//   - Cleared on the gnt.
//   - Also cleared if the locked master drops req (illegal per protocol; tolerated).
//  Grant:
//   - On handshake, push owner id (0=INSTR, 1=DATA) into the FIFO.
//   - Update last_winner.
//  Response path:
//   - mem_rvalid_i with FIFO non-empty: pop head.
//   - Assert head owner's *_rvalid_o the same cycle; *_err_o = mem_err_i.
//   - *_rdata_o = mem_rdata_i broadcast to both masters; only the owner's rvalid qualifies it.
//   - Response may coincide with the grant of the same cycle, but never answers that request (0-cycle response illegal).
//   - mem_rvalid_i with FIFO empty: ignored (no rvalid out); proto_err_o <= 1 until RST.
//  Count arithmetic:
//   - push & pop in the same cycle: count unchanged; else +1 / -1.
//   - FIFO pointers wrap modulo MAX_OUTST.
//   - Count never exceeds MAX_OUTST and never underflows.
//  Reset mid-operation:
//   - All in-flight ownership is discarded; the memory is reset together with this block.
// TESTING
//  1. Single fetch: instr_req, gnt 1st cycle, rvalid 2 cycles later, rdata=0xDEADBEEF
//     -> instr_rvalid_o=1, data 0xDEADBEEF, data_rvalid_o=0, cnt 0->1->0.
//  2. DATA_PRIO=1, both req every cycle with mem_gnt_i=1 -> data wins every grant;
//     mem_we_o/be follow data_*.
//  3. DATA_PRIO=0, both req, mem_gnt_i=1 -> grants alternate D,I,D,I (first is D, last_winner=INSTR).
//  4. MAX_OUTST=2, gnt 3 back-to-back, no rvalid:
//     - 3rd cycle mem_req_o=0.
//     - Responses R1 (err=1), R2 reach the owners in order, with err only on R1.
//  5. Stall: mem_gnt_i=0 for 3 cycles with instr requesting, data raises req mid-stall
//     -> mem_addr_o stays on instr_addr_i until gnt, then data granted next.
//  6. Stray mem_rvalid_i with cnt=0 -> no *_rvalid_o, proto_err_o=1 sticky; RST clears it.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Request/response bus shared by the fetch, LSU and memory sides of the arbiter.
// The master modport issues requests; the slave modport grants and answers them.
// Instruction-fetch masters leave we/be/wdata at zero.
interface mem_port_arbiter_if;
  logic        req;
  logic        we;
  logic [3:0]  be;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;

  modport master (
    output req, we, be, addr, wdata,
    input  gnt, rvalid, rdata, err
  );

  modport slave (
    input  req, we, be, addr, wdata,
    output gnt, rvalid, rdata, err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one req/gnt/rvalid memory port between the fetch and LSU masters.
// Latency: request and response paths are combinational (zero cycles).
// Backpressure: mem gnt low holds the selection locked; full owner FIFO blocks new requests.
module mem_port_arbiter #(
  parameter int MAX_OUTST = 2,
  parameter bit DATA_PRIO = 1'b1
) (
  input  logic                           clk,
  input  logic                           rst,
  mem_port_arbiter_if.slave              instr,
  mem_port_arbiter_if.slave              data,
  mem_port_arbiter_if.master             mem,
  output logic [$clog2(MAX_OUTST+1)-1:0] outst_cnt,
  output logic                           proto_err
);

  localparam int CNT_W = $clog2(MAX_OUTST + 1);
  localparam int PTR_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;

  typedef enum logic {OWN_INSTR = 1'b0, OWN_DATA = 1'b1} owner_e;
  typedef enum logic {ST_OPEN = 1'b0, ST_LOCKED = 1'b1} lock_st_e;

  lock_st_e             st_q, st_d;
  owner_e               lock_own_q, lock_own_d;
  owner_e               last_win_q;
  logic [MAX_OUTST-1:0] own_fifo_q;
  logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 perr_q;

  logic   full, empty, locked_req, sel_vld, mem_req, push, pop;
  owner_e sel, head;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUTST - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full       = (cnt_q == CNT_W'(MAX_OUTST));
  assign empty      = (cnt_q == '0);
  assign locked_req = (lock_own_q == OWN_DATA) ? data.req : instr.req;
  assign head       = owner_e'(own_fifo_q[rd_ptr_q]);

  // Pick the master to present: a locked request sticks until granted or withdrawn.
  always_comb begin
    sel_vld = 1'b0;
    sel     = OWN_INSTR;
    if (st_q == ST_LOCKED && locked_req) begin
      sel_vld = 1'b1;
      sel     = lock_own_q;
    end else if (instr.req && data.req) begin
      sel_vld = 1'b1;
      if (DATA_PRIO) sel = OWN_DATA;
      else           sel = (last_win_q == OWN_INSTR) ? OWN_DATA : OWN_INSTR;
    end else if (data.req) begin
      sel_vld = 1'b1;
      sel     = OWN_DATA;
    end else if (instr.req) begin
      sel_vld = 1'b1;
      sel     = OWN_INSTR;
    end
  end

  assign mem_req = sel_vld && !full && !rst;
  assign push    = mem_req && mem.gnt;
  // The head entry is always an older request, so a same-cycle push is never answered.
  assign pop     = mem.rvalid && !empty && !rst;

  // Drive the memory request fields from the selected master, zero when idle.
  always_comb begin
    mem.req   = mem_req;
    mem.we    = 1'b0;
    mem.be    = 4'h0;
    mem.addr  = 32'h0;
    mem.wdata = 32'h0;
    if (sel_vld && sel == OWN_DATA) begin
      mem.we    = data.we;
      mem.be    = data.be;
      mem.addr  = data.addr;
      mem.wdata = data.wdata;
    end else if (sel_vld) begin
      mem.be    = 4'hF;
      mem.addr  = instr.addr;
    end
  end

  assign instr.gnt    = push && (sel == OWN_INSTR);
  assign data.gnt     = push && (sel == OWN_DATA);
  assign instr.rvalid = pop && (head == OWN_INSTR);
  assign data.rvalid  = pop && (head == OWN_DATA);
  assign instr.err    = instr.rvalid && mem.err;
  assign data.err     = data.rvalid && mem.err;
  assign instr.rdata  = mem.rdata;
  assign data.rdata   = mem.rdata;
  assign outst_cnt    = cnt_q;
  assign proto_err    = perr_q;

  // Lock FSM next state: lock on an unacknowledged request, release on gnt or dropped req.
  always_comb begin
    st_d       = st_q;
    lock_own_d = lock_own_q;
    case (st_q)
      ST_OPEN: begin
        if (mem_req && !mem.gnt) begin
          st_d       = ST_LOCKED;
          lock_own_d = sel;
        end
      end
      ST_LOCKED: begin
        if (mem_req && !mem.gnt) begin
          lock_own_d = sel;
        end else if (mem_req && mem.gnt) begin
          st_d = ST_OPEN;
        end else if (!locked_req) begin
          st_d = ST_OPEN;
        end
      end
      default: st_d = ST_OPEN;
    endcase
  end

  // Lock FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q       <= ST_OPEN;
      lock_own_q <= OWN_INSTR;
    end else begin
      st_q       <= st_d;
      lock_own_q <= lock_own_d;
    end
  end

  // Owner FIFO, in-flight count, round-robin history and sticky protocol error.
  always_ff @(posedge clk) begin
    if (rst) begin
      own_fifo_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      last_win_q <= OWN_INSTR;
      perr_q     <= 1'b0;
    end else begin
      if (push) begin
        own_fifo_q[wr_ptr_q] <= sel;
        wr_ptr_q             <= ptr_inc(wr_ptr_q);
        last_win_q           <= sel;
      end
      if (pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
      if (mem.rvalid && empty) begin
        perr_q <= 1'b1;
      end
    end
  end

endmodule
